// File: rtl/immediate_decode_stage.sv
// RV32I immediate decode stage: extracts/sign-extends immediates, 2-entry skid buffer on the output.
// Optional `illegal` output enabled by defining ILLEGAL_OPCODE_DETECT_EN.
package immediate_decode_pkg;
  typedef enum logic {ModeLui = 1'b0, ModeAuipc = 1'b1} ImmediateFormerMode_t;
endpackage

module immediate_decode_stage
  import immediate_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                 clock,
  input  logic                 nReset,
  input  logic                 flush,
  input  logic                 instValid,
  output logic                 instReady,
  input  logic [31:0]          instruction,
  input  logic [31:0]          pcIn,
  output logic                 decValid,
  input  logic                 decReady,
  output logic [XLEN-1:0]      immediate,
  output logic [2:0]           immType,
  output logic                 uForm,
  output ImmediateFormerMode_t immediateFormerMode,
  output logic [31:0]          pcOut,
  output logic [4:0]           rd,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
`ifdef ILLEGAL_OPCODE_DETECT_EN
  output logic                 illegal,
`endif
  output logic [2:0]           funct3
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("immediate_decode_stage: only XLEN=32 is supported");
  end

  localparam logic [2:0] TypeNone = 3'd0;
  localparam logic [2:0] TypeI    = 3'd1;
  localparam logic [2:0] TypeS    = 3'd2;
  localparam logic [2:0] TypeB    = 3'd3;
  localparam logic [2:0] TypeU    = 3'd4;
  localparam logic [2:0] TypeJ    = 3'd5;

  typedef struct packed {
    logic [31:0]          imm;
    logic [2:0]           typ;
    logic                 uform;
    ImmediateFormerMode_t mode;
    logic [31:0]          pc;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [2:0]           f3;
`ifdef ILLEGAL_OPCODE_DETECT_EN
    logic                 ill;
`endif
  } bundle_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e  state_q;
  bundle_t main_q, skid_q, dec_d;
  logic    in_xfer, out_xfer;

  always_comb begin
    dec_d      = '0;
    dec_d.mode = ModeLui;
    dec_d.pc   = pcIn;
    dec_d.rd   = instruction[11:7];
    dec_d.rs1  = instruction[19:15];
    dec_d.rs2  = instruction[24:20];
    dec_d.f3   = instruction[14:12];
    case (instruction[6:0])
      7'b0110111: begin
        dec_d.typ   = TypeU;
        dec_d.uform = 1'b1;
        dec_d.imm   = {instruction[31:12], 12'b0};
      end
      7'b0010111: begin
        dec_d.typ   = TypeU;
        dec_d.uform = 1'b1;
        dec_d.mode  = ModeAuipc;
        dec_d.imm   = {instruction[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_d.typ = TypeJ;
        dec_d.imm = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                     instruction[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
        dec_d.typ = TypeI;
        dec_d.imm = {{21{instruction[31]}}, instruction[30:20]};
      end
      7'b0100011: begin
        dec_d.typ = TypeS;
        dec_d.imm = {{21{instruction[31]}}, instruction[30:25], instruction[11:7]};
      end
      7'b1100011: begin
        dec_d.typ = TypeB;
        dec_d.imm = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                     instruction[11:8], 1'b0};
      end
      7'b0110011: dec_d.typ = TypeNone;
      default: begin
        // Opcodes outside the map (including instr[1:0]!=2'b11) decode as no immediate.
`ifdef ILLEGAL_OPCODE_DETECT_EN
        dec_d.ill = 1'b1;
`endif
      end
    endcase
  end

  assign instReady = (state_q != StTwo);
  assign decValid  = (state_q != StEmpty);
  assign in_xfer   = instValid & instReady;
  assign out_xfer  = decValid & decReady;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            main_q  <= dec_d;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (in_xfer && !out_xfer) begin
            skid_q  <= dec_d;
            state_q <= StTwo;
          end else if (in_xfer && out_xfer) begin
            main_q <= dec_d;
          end else if (out_xfer) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign immediate           = main_q.imm;
  assign immType             = main_q.typ;
  assign uForm               = main_q.uform;
  assign immediateFormerMode = main_q.mode;
  assign pcOut               = main_q.pc;
  assign rd                  = main_q.rd;
  assign rs1                 = main_q.rs1;
  assign rs2                 = main_q.rs2;
  assign funct3              = main_q.f3;
`ifdef ILLEGAL_OPCODE_DETECT_EN
  assign illegal             = main_q.ill;
`endif

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Self-checking bench for immediate_decode_stage: directed decode vectors plus
// backpressure, flush and mid-stream reset sequences.
module tb_immediate_decode_stage;
  import immediate_decode_pkg::*;

  logic                 clock, nReset, flush, instValid, instReady, decValid, decReady;
  logic [31:0]          instruction, pcIn, immediate, pcOut;
  logic [2:0]           immType, funct3;
  logic                 uForm;
  ImmediateFormerMode_t immediateFormerMode;
  logic [4:0]           rd, rs1, rs2;
`ifdef ILLEGAL_OPCODE_DETECT_EN
  logic                 illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  immediate_decode_stage #(.XLEN(32)) dut (
    .clock              (clock),
    .nReset             (nReset),
    .flush              (flush),
    .instValid          (instValid),
    .instReady          (instReady),
    .instruction        (instruction),
    .pcIn               (pcIn),
    .decValid           (decValid),
    .decReady           (decReady),
    .immediate          (immediate),
    .immType            (immType),
    .uForm              (uForm),
    .immediateFormerMode(immediateFormerMode),
    .pcOut              (pcOut),
    .rd                 (rd),
    .rs1                (rs1),
    .rs2                (rs2),
`ifdef ILLEGAL_OPCODE_DETECT_EN
    .illegal            (illegal),
`endif
    .funct3             (funct3)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]          instr;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic [2:0]           typ;
    logic                 uform;
    ImmediateFormerMode_t mode;
    logic                 ill;
  } vec_t;

  localparam int NVec = 13;
  vec_t vecs [NVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input vec_t v);
    logic [31:0] w;
    w = v.instr;
    chk({tag, " decValid"}, {31'b0, decValid}, 32'd1);
    chk({tag, " immediate"}, immediate, v.imm);
    chk({tag, " immType"}, {29'b0, immType}, {29'b0, v.typ});
    chk({tag, " uForm"}, {31'b0, uForm}, {31'b0, v.uform});
    chk({tag, " mode"}, {31'b0, immediateFormerMode}, {31'b0, v.mode});
    chk({tag, " pcOut"}, pcOut, v.pc);
    chk({tag, " rd"}, {27'b0, rd}, {27'b0, w[11:7]});
    chk({tag, " rs1"}, {27'b0, rs1}, {27'b0, w[19:15]});
    chk({tag, " rs2"}, {27'b0, rs2}, {27'b0, w[24:20]});
    chk({tag, " funct3"}, {29'b0, funct3}, {29'b0, w[14:12]});
`ifdef ILLEGAL_OPCODE_DETECT_EN
    chk({tag, " illegal"}, {31'b0, illegal}, {31'b0, v.ill});
`endif
  endtask

  task automatic offer(input vec_t v);
    instValid   = 1'b1;
    instruction = v.instr;
    pcIn        = v.pc;
  endtask

  initial begin
    // instr, pc, imm, type, uform, mode, illegal
    vecs[0]  = '{32'h12345537, 32'h0000_0000, 32'h12345000, 3'd4, 1'b1, ModeLui,   1'b0};
    vecs[1]  = '{32'h00001097, 32'h0000_0100, 32'h00001000, 3'd4, 1'b1, ModeAuipc, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 32'h0000_0104, 32'hFFFFFFFC, 3'd3, 1'b0, ModeLui,   1'b0};
    vecs[3]  = '{32'h001000EF, 32'h0000_0108, 32'h00000800, 3'd5, 1'b0, ModeLui,   1'b0};
    vecs[4]  = '{32'hFFF00093, 32'h0000_010C, 32'hFFFFFFFF, 3'd1, 1'b0, ModeLui,   1'b0};
    vecs[5]  = '{32'h80002003, 32'h0000_0110, 32'hFFFFF800, 3'd1, 1'b0, ModeLui,   1'b0};
    vecs[6]  = '{32'h00112623, 32'h0000_0114, 32'h0000000C, 3'd2, 1'b0, ModeLui,   1'b0};
    vecs[7]  = '{32'hFE112E23, 32'h0000_0118, 32'hFFFFFFFC, 3'd2, 1'b0, ModeLui,   1'b0};
    vecs[8]  = '{32'h002081B3, 32'h0000_011C, 32'h00000000, 3'd0, 1'b0, ModeLui,   1'b0};
    vecs[9]  = '{32'h30529073, 32'h0000_0120, 32'h00000305, 3'd1, 1'b0, ModeLui,   1'b0};
    vecs[10] = '{32'h000080E7, 32'h0000_0124, 32'h00000000, 3'd1, 1'b0, ModeLui,   1'b0};
    vecs[11] = '{32'h0000007F, 32'h0000_0128, 32'h00000000, 3'd0, 1'b0, ModeLui,   1'b1};
    vecs[12] = '{32'h00000013, 32'h0000_012C, 32'h00000000, 3'd1, 1'b0, ModeLui,   1'b0};

    clock = 1'b0; nReset = 1'b0; flush = 1'b0; instValid = 1'b0; decReady = 1'b0;
    instruction = 32'h0; pcIn = 32'h0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("reset decValid", {31'b0, decValid}, 32'd0);
    chk("reset instReady", {31'b0, instReady}, 32'd1);
    chk("reset immediate", immediate, 32'h0);
    chk("reset pcOut", pcOut, 32'h0);
    chk("reset immType", {29'b0, immType}, 32'd0);
    nReset = 1'b1;
    @(negedge clock);

    // Streaming decode, one new bundle per cycle with decReady held high
    decReady = 1'b1;
    for (int i = 0; i < NVec; i++) begin
      offer(vecs[i]);
      chk($sformatf("vec%0d instReady", i), {31'b0, instReady}, 32'd1);
      @(negedge clock);
      check_out($sformatf("vec%0d", i), vecs[i]);
    end
    instValid = 1'b0;
    @(negedge clock);
    chk("drain decValid", {31'b0, decValid}, 32'd0);

    // Backpressure: three back-to-back offers with decReady low
    decReady = 1'b0;
    offer(vecs[0]);
    @(negedge clock);
    check_out("bp A", vecs[0]);
    offer(vecs[1]);
    @(negedge clock);
    chk("bp full instReady", {31'b0, instReady}, 32'd0);
    check_out("bp A held", vecs[0]);
    offer(vecs[2]);
    @(negedge clock);
    chk("bp C blocked", {31'b0, instReady}, 32'd0);
    check_out("bp A stall", vecs[0]);
    decReady = 1'b1;
    @(negedge clock);
    check_out("bp B", vecs[1]);
    chk("bp ready again", {31'b0, instReady}, 32'd1);
    @(negedge clock);
    check_out("bp C", vecs[2]);
    instValid = 1'b0;
    @(negedge clock);
    chk("bp empty", {31'b0, decValid}, 32'd0);

    // Flush in TWO with an input offered
    decReady = 1'b0;
    offer(vecs[3]);
    @(negedge clock);
    offer(vecs[4]);
    @(negedge clock);
    chk("pre-flush instReady", {31'b0, instReady}, 32'd0);
    flush = 1'b1;
    offer(vecs[5]);
    @(negedge clock);
    flush = 1'b0;
    instValid = 1'b0;
    chk("flush2 decValid", {31'b0, decValid}, 32'd0);
    chk("flush2 instReady", {31'b0, instReady}, 32'd1);
    @(negedge clock);
    chk("flush2 stays empty", {31'b0, decValid}, 32'd0);

    // Flush in ONE while the input is acceptable: the input must be dropped
    offer(vecs[6]);
    @(negedge clock);
    check_out("pre-flush1", vecs[6]);
    flush = 1'b1;
    offer(vecs[7]);
    @(negedge clock);
    flush = 1'b0;
    instValid = 1'b0;
    chk("flush1 decValid", {31'b0, decValid}, 32'd0);
    @(negedge clock);
    chk("flush1 input dropped", {31'b0, decValid}, 32'd0);

    // Asynchronous reset mid-stream
    decReady = 1'b1;
    offer(vecs[0]);
    @(negedge clock);
    check_out("pre-reset", vecs[0]);
    #2 nReset = 1'b0;
    #1;
    chk("async rst decValid", {31'b0, decValid}, 32'd0);
    chk("async rst immediate", immediate, 32'h0);
    chk("async rst pcOut", pcOut, 32'h0);
    chk("async rst rd", {27'b0, rd}, 32'd0);
    chk("async rst instReady", {31'b0, instReady}, 32'd1);
    instValid = 1'b0;
    @(negedge clock);
    nReset = 1'b1;
    @(negedge clock);
    chk("post-reset decValid", {31'b0, decValid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
